// File: rtl/interrupt_source_latch.sv
// ============================================================================
// interrupt_source_latch
//
// Latches the two interrupt sources of an 8051-style core (external INT0 and
// timer 0 overflow), arbitrates between them and runs a small request /
// service handshake with the CPU interrupt controller.
//
// Ports
//   clock       in   1  system clock, rising edge
//   reset       in   1  synchronous, active-high reset
//   int0_n      in   1  external interrupt pin, active low, asynchronous
//   it0         in   1  INT0 trigger select: 1 = falling edge, 0 = level
//   tf0_set     in   1  one-cycle timer 0 overflow pulse
//   ea          in   1  global interrupt enable
//   ex0         in   1  external 0 interrupt enable
//   et0         in   1  timer 0 interrupt enable
//   int_ack     in   1  one-cycle CPU acknowledge of the current request
//   reti        in   1  one-cycle end-of-ISR pulse
//   flag_clr    in   2  software flag clear: [0] = IE0, [1] = TF0
//   int_req     out  1  registered interrupt request
//   int_pend    out  1  request source: 1 = timer 0 (0x0B), 0 = ext 0 (0x03)
//   ie0         out  1  IE0 flag (TCON)
//   tf0         out  1  TF0 flag (TCON)
//   in_service  out  1  high while an acknowledged interrupt is serviced
//
// Timing
//   int0_n falling edge -> ie0 three clocks later (two sync flops + flag).
//   tf0_set in cycle N  -> tf0 in N+1, int_req in N+2.
//   All outputs come straight from flops.
// ============================================================================
module interrupt_source_latch (
    input  logic       clock,
    input  logic       reset,
    input  logic       int0_n,
    input  logic       it0,
    input  logic       tf0_set,
    input  logic       ea,
    input  logic       ex0,
    input  logic       et0,
    input  logic       int_ack,
    input  logic       reti,
    input  logic [1:0] flag_clr,
    output logic       int_req,
    output logic       int_pend,
    output logic       ie0,
    output logic       tf0,
    output logic       in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic   r_sync1;
    logic   r_sync2;
    logic   r_hist;
    logic   r_ie0;
    logic   r_tf0;
    state_t r_state;
    state_t w_state_nxt;
    logic   r_int_req;
    logic   r_int_pend;
    logic   r_in_service;

    logic   w_s_int0_n;
    logic   w_fall;
    logic   w_ext_elig;
    logic   w_tmr_elig;
    logic   w_elig;
    logic   w_sel_valid;
    logic   w_ack_take;
    logic   w_ie0_clr;
    logic   w_tf0_clr;
    logic   w_ie0_nxt;
    logic   w_tf0_nxt;
    logic   w_int_req_nxt;
    logic   w_int_pend_nxt;
    logic   w_in_service_nxt;

    // ------------------------------------------------------------------
    // INT0 synchronizer and edge history.
    // All three flops reset to the idle (high) pin level so that leaving
    // reset can never look like a falling edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= int0_n;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_s_int0_n = r_sync2;
    assign w_fall     = r_hist & ~w_s_int0_n;

    // ------------------------------------------------------------------
    // Eligibility and acknowledge qualification
    // ------------------------------------------------------------------
    assign w_ext_elig = r_ie0 & ex0;
    assign w_tmr_elig = r_tf0 & et0;
    assign w_elig     = ea & (w_ext_elig | w_tmr_elig);

    // The latched source must still be flagged and enabled for the request
    // to stand; otherwise the request is withdrawn rather than acknowledged.
    assign w_sel_valid = ea & (r_int_pend ? w_tmr_elig : w_ext_elig);
    assign w_ack_take  = (r_state == ST_REQUEST) & w_sel_valid & int_ack;

    // ------------------------------------------------------------------
    // Flags. Set beats clear when both happen in one cycle.
    // Level mode registers the inverted synchronized pin every cycle, so
    // acknowledge and software clear cannot remove a held-low request.
    // ------------------------------------------------------------------
    assign w_ie0_clr = flag_clr[0] | (w_ack_take & ~r_int_pend);
    assign w_tf0_clr = flag_clr[1] | (w_ack_take &  r_int_pend);

    always_comb begin
        w_ie0_nxt = r_ie0;
        if (it0) begin
            w_ie0_nxt = w_fall | (r_ie0 & ~w_ie0_clr);
        end else begin
            w_ie0_nxt = ~w_s_int0_n;
        end
    end

    assign w_tf0_nxt = tf0_set | (r_tf0 & ~w_tf0_clr);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ie0 <= 1'b0;
            r_tf0 <= 1'b0;
        end else begin
            r_ie0 <= w_ie0_nxt;
            r_tf0 <= w_tf0_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_elig) begin
                    w_state_nxt = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // Withdrawal wins over a coincident acknowledge.
                if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (int_ack) begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the next state and then registered so
    // they line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_int_req_nxt    = (w_state_nxt == ST_REQUEST);
        w_in_service_nxt = (w_state_nxt == ST_SERVICE);
        w_int_pend_nxt   = r_int_pend;
        // Source is captured only on entry to REQUEST; external wins.
        if ((r_state == ST_IDLE) && (w_state_nxt == ST_REQUEST)) begin
            w_int_pend_nxt = ~w_ext_elig;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_int_req    <= 1'b0;
            r_int_pend   <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_int_req    <= w_int_req_nxt;
            r_int_pend   <= w_int_pend_nxt;
            r_in_service <= w_in_service_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign int_req    = r_int_req;
    assign int_pend   = r_int_pend;
    assign in_service = r_in_service;
    assign ie0        = r_ie0;
    assign tf0        = r_tf0;

endmodule

// File: tb/tb_interrupt_source_latch.sv
// Bench for interrupt_source_latch. Directed scenarios check fixed cycle
// timings against constants; the random phase checks every cycle against a
// source-level reference model. outs = {int_req, int_pend, in_service, ie0, tf0}.
module tb_interrupt_source_latch;

    logic       clock = 1'b0;
    logic       reset;
    logic       int0_n;
    logic       it0;
    logic       tf0_set;
    logic       ea;
    logic       ex0;
    logic       et0;
    logic       int_ack;
    logic       reti;
    logic [1:0] flag_clr;
    logic       int_req;
    logic       int_pend;
    logic       ie0;
    logic       tf0;
    logic       in_service;
    logic [4:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_source_latch dut (
        .clock      (clock),
        .reset      (reset),
        .int0_n     (int0_n),
        .it0        (it0),
        .tf0_set    (tf0_set),
        .ea         (ea),
        .ex0        (ex0),
        .et0        (et0),
        .int_ack    (int_ack),
        .reti       (reti),
        .flag_clr   (flag_clr),
        .int_req    (int_req),
        .int_pend   (int_pend),
        .ie0        (ie0),
        .tf0        (tf0),
        .in_service (in_service)
    );

    always #5 clock = ~clock;

    assign outs = {int_req, int_pend, in_service, ie0, tf0};

    // ------------------------------------------------------------------
    // Reference model. The pin is seen two samples late; phase 0 = idle,
    // 1 = requesting, 2 = servicing; m_src is the chosen source (1 = timer).
    // ------------------------------------------------------------------
    bit [2:0] m_pin = 3'b111;   // [0] newest sample of int0_n
    bit       m_ie0 = 1'b0;
    bit       m_tf0 = 1'b0;
    int       m_phase = 0;
    bit       m_src = 1'b0;
    bit       m_sel_ok;
    bit       m_elig;
    bit       m_ack;
    logic [4:0] m_outs;

    always_comb begin
        m_elig   = ea && ((m_ie0 && ex0) || (m_tf0 && et0));
        m_sel_ok = ea && (m_src ? (m_tf0 && et0) : (m_ie0 && ex0));
        m_ack    = (m_phase == 1) && m_sel_ok && int_ack;
        m_outs   = {m_phase == 1, m_src, m_phase == 2, m_ie0, m_tf0};
    end

    always @(posedge clock) begin
        if (reset) begin
            m_pin   <= 3'b111;
            m_ie0   <= 1'b0;
            m_tf0   <= 1'b0;
            m_phase <= 0;
            m_src   <= 1'b0;
        end else begin
            m_pin <= {m_pin[1:0], int0_n};
            if (it0)
                m_ie0 <= (m_pin[2] && !m_pin[1]) ||
                         (m_ie0 && !(flag_clr[0] || (m_ack && !m_src)));
            else
                m_ie0 <= !m_pin[1];
            m_tf0 <= tf0_set || (m_tf0 && !(flag_clr[1] || (m_ack && m_src)));
            if (m_phase == 0 && m_elig) begin
                m_phase <= 1;
                m_src   <= !(m_ie0 && ex0);
            end else if (m_phase == 1 && !m_sel_ok) begin
                m_phase <= 0;
            end else if (m_phase == 1 && int_ack) begin
                m_phase <= 2;
            end else if (m_phase == 2 && reti) begin
                m_phase <= 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        int0_n   = 1'b1;
        it0      = 1'b1;
        tf0_set  = 1'b0;
        ea       = 1'b0;
        ex0      = 1'b0;
        et0      = 1'b0;
        int_ack  = 1'b0;
        reti     = 1'b0;
        flag_clr = 2'b00;
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        quiet_inputs();
        reset   = 1'b1;
        tf0_set = 1'b1;
        int0_n  = 1'b0;
        ea = 1'b1; ex0 = 1'b1; et0 = 1'b1;
        tick();
        if (outs !== 5'b00000) begin n_err++; $display("FAIL reset_prio: outs=%b want 00000", outs); end
        n_cmp++;
        tf0_set = 1'b0;
        int0_n  = 1'b1;
        it0     = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (outs !== 5'b00000) begin n_err++; $display("FAIL reset_release_lvl[%0d]: outs=%b want 00000", i, outs); end
            n_cmp++;
        end
    endtask

    task automatic test_timer_request();
        do_reset();
        ea = 1'b1; et0 = 1'b1;
        tf0_set = 1'b1;                       // cycle 10
        tick();
        tf0_set = 1'b0;
        if (outs !== 5'b00001) begin n_err++; $display("FAIL tmr_flag: outs=%b want 00001", outs); end
        n_cmp++;
        tick();                               // cycle 12
        if (outs !== 5'b11001) begin n_err++; $display("FAIL tmr_req: outs=%b want 11001", outs); end
        n_cmp++;
        tick(); tick(); tick();               // cycle 15
        int_ack = 1'b1;
        tick();                               // cycle 16
        int_ack = 1'b0;
        if (outs !== 5'b01100) begin n_err++; $display("FAIL tmr_ack: outs=%b want 01100", outs); end
        n_cmp++;
        tick(); tick(); tick(); tick();       // cycle 20
        if (outs !== 5'b01100) begin n_err++; $display("FAIL tmr_svc_hold: outs=%b want 01100", outs); end
        n_cmp++;
        reti = 1'b1;
        tick();                               // cycle 21
        reti = 1'b0;
        if (outs !== 5'b01000) begin n_err++; $display("FAIL tmr_reti: outs=%b want 01000", outs); end
        n_cmp++;
    endtask

    task automatic test_ext_edge();
        do_reset();
        ea = 1'b1; ex0 = 1'b1; it0 = 1'b1;
        tick();
        int0_n = 1'b0;                        // cycle 5
        tick(); tick();                       // cycle 7
        if (outs !== 5'b00000) begin n_err++; $display("FAIL ext_early: outs=%b want 00000", outs); end
        n_cmp++;
        tick();                               // cycle 8
        if (outs !== 5'b00010) begin n_err++; $display("FAIL ext_flag: outs=%b want 00010", outs); end
        n_cmp++;
        tick();                               // cycle 9
        if (outs !== 5'b10010) begin n_err++; $display("FAIL ext_req: outs=%b want 10010", outs); end
        n_cmp++;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        if (outs !== 5'b00100) begin n_err++; $display("FAIL ext_ack: outs=%b want 00100", outs); end
        n_cmp++;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        int0_n = 1'b1;                        // rising edge must not set ie0
        tick(); tick(); tick(); tick();
        if (outs !== 5'b00000) begin n_err++; $display("FAIL ext_rise: outs=%b want 00000", outs); end
        n_cmp++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        ea = 1'b1; ex0 = 1'b1; et0 = 1'b1; it0 = 1'b1;
        int0_n = 1'b0;
        tick(); tick();
        tf0_set = 1'b1;
        tick();
        tf0_set = 1'b0;
        if (outs !== 5'b00011) begin n_err++; $display("FAIL both_flags: outs=%b want 00011", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b10011) begin n_err++; $display("FAIL both_ext_first: outs=%b want 10011", outs); end
        n_cmp++;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        if (outs !== 5'b00101) begin n_err++; $display("FAIL both_ack1: outs=%b want 00101", outs); end
        n_cmp++;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        if (outs !== 5'b00001) begin n_err++; $display("FAIL both_reti1: outs=%b want 00001", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b11001) begin n_err++; $display("FAIL both_req2: outs=%b want 11001", outs); end
        n_cmp++;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        if (outs !== 5'b01100) begin n_err++; $display("FAIL both_ack2: outs=%b want 01100", outs); end
        n_cmp++;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        int0_n = 1'b1;
    endtask

    task automatic test_ea_drop();
        do_reset();
        ea = 1'b1; et0 = 1'b1;
        tf0_set = 1'b1;
        tick();
        tf0_set = 1'b0;
        tick();
        if (outs !== 5'b11001) begin n_err++; $display("FAIL drop_req: outs=%b want 11001", outs); end
        n_cmp++;
        ea = 1'b0;
        tick();
        if (outs !== 5'b01001) begin n_err++; $display("FAIL drop_idle: outs=%b want 01001", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b01001) begin n_err++; $display("FAIL drop_stay: outs=%b want 01001", outs); end
        n_cmp++;
        ea = 1'b1;
        tick();
        if (outs !== 5'b11001) begin n_err++; $display("FAIL drop_rereq: outs=%b want 11001", outs); end
        n_cmp++;
        flag_clr = 2'b10;
        tick();
        flag_clr = 2'b00;
        if (outs !== 5'b11000) begin n_err++; $display("FAIL drop_swclr: outs=%b want 11000", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b01000) begin n_err++; $display("FAIL drop_withdraw: outs=%b want 01000", outs); end
        n_cmp++;
    endtask

    task automatic test_level_hold();
        do_reset();
        it0 = 1'b0; ea = 1'b1; ex0 = 1'b1;
        int0_n = 1'b0;
        tick(); tick(); tick();
        if (outs !== 5'b00010) begin n_err++; $display("FAIL lvl_flag: outs=%b want 00010", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b10010) begin n_err++; $display("FAIL lvl_req: outs=%b want 10010", outs); end
        n_cmp++;
        int_ack  = 1'b1;
        flag_clr = 2'b01;
        tick();
        int_ack  = 1'b0;
        flag_clr = 2'b00;
        if (outs !== 5'b00110) begin n_err++; $display("FAIL lvl_ack_keep: outs=%b want 00110", outs); end
        n_cmp++;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        if (outs !== 5'b00010) begin n_err++; $display("FAIL lvl_reti: outs=%b want 00010", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b10010) begin n_err++; $display("FAIL lvl_rereq: outs=%b want 10010", outs); end
        n_cmp++;
        int0_n = 1'b1;
        tick(); tick(); tick();
        if (outs !== 5'b10000) begin n_err++; $display("FAIL lvl_release: outs=%b want 10000", outs); end
        n_cmp++;
        tick();
        if (outs !== 5'b00000) begin n_err++; $display("FAIL lvl_withdraw: outs=%b want 00000", outs); end
        n_cmp++;
    endtask

    task automatic test_reset_in_service();
        do_reset();
        ea = 1'b1; et0 = 1'b1; ex0 = 1'b1; it0 = 1'b1;
        tf0_set = 1'b1;
        tick();
        tf0_set = 1'b0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tf0_set = 1'b1;
        tick();
        tf0_set = 1'b0;
        if (outs !== 5'b01101) begin n_err++; $display("FAIL rsvc_pending: outs=%b want 01101", outs); end
        n_cmp++;
        reset = 1'b1;
        tick();
        if (outs !== 5'b00000) begin n_err++; $display("FAIL rsvc_reset: outs=%b want 00000", outs); end
        n_cmp++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (outs !== 5'b00000) begin n_err++; $display("FAIL rsvc_release[%0d]: outs=%b want 00000", i, outs); end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0)  int0_n = ~int0_n;
            if ($urandom_range(0, 63) == 0) it0 = ~it0;
            tf0_set  = ($urandom_range(0, 7) == 0);
            ea       = ($urandom_range(0, 15) != 0);
            ex0      = ($urandom_range(0, 7) != 0);
            et0      = ($urandom_range(0, 7) != 0);
            int_ack  = ($urandom_range(0, 2) == 0);
            reti     = ($urandom_range(0, 5) == 0);
            flag_clr = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tick();
            if (outs !== m_outs) begin
                n_err++;
                $display("FAIL rand[%0d]: outs=%b want %b", i, outs, m_outs);
            end
            n_cmp++;
        end
        reset = 1'b0;
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        test_reset();
        test_timer_request();
        test_ext_edge();
        test_simultaneous();
        test_ea_drop();
        test_level_hold();
        test_reset_in_service();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_source_latch.md
INTERRUPT_SOURCE_LATCH -- requirements
Module: interrupt_source_latch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 int0_n  input  1  external interrupt pin, active low, asynchronous to clock.
REQ-005 it0  input  1  INT0 trigger select: 1 = falling-edge triggered, 0 = level triggered.
REQ-006 tf0_set  input  1  one-cycle pulse marking a timer 0 overflow.
REQ-007 ea, ex0, et0  input  1 each  global, external-0 and timer-0 interrupt enables.
REQ-008 int_ack  input  1  one-cycle CPU acknowledge of the current request.
REQ-009 reti  input  1  one-cycle pulse marking the end of the interrupt service routine.
REQ-010 flag_clr  input  2  software clear of flags: bit0 clears IE0, bit1 clears TF0.
REQ-011 int_req  output  1  registered interrupt request to the interrupt controller.
REQ-012 int_pend  output  1  source of the current request: 1 = timer 0 (vector 0x0B), 0 = external 0 (vector 0x03).
REQ-013 ie0, tf0  output  1 each  current flag state, readable as TCON bits.
REQ-014 in_service  output  1  high while an acknowledged interrupt is being serviced.

Function
REQ-015 int0_n SHALL pass through a two-flop synchronizer; every later logic stage SHALL use only the synchronized value s_int0_n.
REQ-016 In edge mode (it0=1), a 1->0 transition of s_int0_n SHALL set ie0; latency is 3 clocks from the pin change to ie0=1.
REQ-017 In level mode (it0=0), ie0 SHALL equal the inverse of s_int0_n on every cycle; int_ack and flag_clr[0] SHALL have no effect on ie0.
REQ-018 In edge mode, ie0 SHALL clear on int_ack when the latched source is external, or on flag_clr[0]; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-019 tf0 SHALL set the cycle after tf0_set; tf0 SHALL clear on int_ack when the latched source is timer, or on flag_clr[1]; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-020 Eligibility SHALL be defined as elig = ea & ((ie0 & ex0) | (tf0 & et0)).
REQ-021 The block SHALL contain a three-state FSM with states IDLE, REQUEST and SERVICE; the encoding SHALL be internal to the block.
REQ-022 From IDLE with elig=1, the FSM SHALL go to REQUEST and latch the source, with external having priority over timer (int_pend = ~(ie0 & ex0)).
REQ-023 In REQUEST, int_req SHALL be 1 and int_pend SHALL be held stable until the FSM leaves the state.
REQ-024 In REQUEST, int_ack SHALL move the FSM to SERVICE and clear the selected flag per REQ-018 and REQ-019.
REQ-025 In REQUEST, if the selected source's flag, its enable or ea goes low before int_ack, the FSM SHALL return to IDLE; int_req SHALL drop in the next cycle.
REQ-026 In SERVICE, int_req SHALL be 0 and in_service SHALL be 1; new flags SHALL still set and SHALL be held pending.
REQ-027 In SERVICE, reti SHALL return the FSM to IDLE; a pending request SHALL re-enter REQUEST no earlier than the cycle after IDLE.
REQ-028 int_ack outside REQUEST and reti outside SERVICE SHALL be ignored.
REQ-029 int_req, int_pend and in_service SHALL be registered decodes of the FSM state; no output may depend combinationally on any input.
REQ-030 Request latency SHALL be: tf0_set in cycle N gives tf0=1 in cycle N+1 and int_req=1 in cycle N+2.

Reset
REQ-031 When reset=1, the FSM SHALL go to IDLE and ie0, tf0, int_req, int_pend and in_service SHALL all be 0.
REQ-032 Both synchronizer flops and the edge-history flop SHALL reset to 1 (pin idle), so no false edge is detected after reset.
REQ-033 reset SHALL take priority over every other input, including during REQUEST or SERVICE.

Verification
REQ-034 The bench SHALL cover: ea=1, et0=1, tf0_set pulse at cycle 10 -> tf0=1 at 11, int_req=1 and int_pend=1 at 12; int_ack at 15 -> tf0=0 and in_service=1 at 16; reti at 20 -> in_service=0 at 21.
REQ-035 The bench SHALL cover: it0=1, ex0=1, ea=1, int0_n falling at cycle 5 -> ie0=1 at 8 and int_req=1, int_pend=0 at 9; int_ack -> ie0=0.
REQ-036 The bench SHALL cover: ie0 and tf0 set in the same cycle with both enables on -> int_pend=0; after ack and reti -> a second request with int_pend=1 and no lost flag.
REQ-037 The bench SHALL cover: REQUEST active, then ea dropped before int_ack -> int_req=0 one cycle later, FSM in IDLE, flag still 1.
REQ-038 The bench SHALL cover: it0=0 with int0_n held low across int_ack -> ie0 stays 1 and the request reasserts after reti.
REQ-039 The bench SHALL cover: reset asserted in SERVICE with tf0=1 -> the next cycle shows all outputs 0, and holding int0_n=1 through reset release sets no flag.
